// File: rtl/router_pkt_src.sv
`default_nettype none
// =============================================================================
// router_pkt_src : packet source for the 1x3 router input port
//   Buffers a payload, then sends header, payload and parity under busy control
// Revision: 1.0
// =============================================================================
module router_pkt_src #(
  parameter int MAX_LEN    = 63,
  parameter int GAP_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [1:0] dest_addr,
  input  logic [5:0] pay_len,
  input  logic [7:0] pay_data,
  input  logic       pay_valid,
  output logic       pay_ready,
  input  logic       busy,
  output logic [7:0] data_out,
  output logic       pkt_valid,
  output logic       tx_ready,
  output logic       done,
  output logic       req_err
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_COLLECT = 3'd1,
    S_HEADER  = 3'd2,
    S_PAYLOAD = 3'd3,
    S_PARITY  = 3'd4,
    S_GAP     = 3'd5
  } state_t;

  localparam logic [5:0] c_max_len = 6'(MAX_LEN);
  localparam int c_gap_w = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [c_gap_w-1:0] c_gap_last = c_gap_w'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  state_t               r_state;
  state_t               w_next;
  logic [1:0]           r_addr;
  logic [5:0]           r_len;
  logic [5:0]           r_wr_idx;
  logic [5:0]           r_rd_idx;
  logic [7:0]           r_parity;
  logic [c_gap_w-1:0]   r_gap_cnt;
  logic                 r_done;
  logic                 r_req_err;
  logic [7:0]           r_buf [0:MAX_LEN-1];

  logic                 w_req_ok;
  logic                 w_last_wr;
  logic                 w_last_rd;
  logic                 w_gap_end;
  logic [7:0]           w_header;

  assign w_req_ok  = (dest_addr != 2'd3) && (pay_len != 6'd0) && (pay_len <= c_max_len);
  assign w_last_wr = (r_wr_idx == r_len - 6'd1);
  assign w_last_rd = (r_rd_idx == r_len - 6'd1);
  assign w_gap_end = (r_gap_cnt == c_gap_last);
  assign w_header  = {r_len, r_addr};

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (start && w_req_ok)      w_next = S_COLLECT;
      S_COLLECT: if (pay_valid && w_last_wr) w_next = S_HEADER;
      S_HEADER:  if (!busy)                  w_next = S_PAYLOAD;
      S_PAYLOAD: if (!busy && w_last_rd)     w_next = S_PARITY;
      S_PARITY:  if (!busy)                  w_next = (GAP_CYCLES == 0) ? S_IDLE : S_GAP;
      S_GAP:     if (w_gap_end)              w_next = S_IDLE;
      default:                               w_next = S_IDLE;
    endcase
  end

  // Parity accumulates payload while collecting and folds in the header when it is sent
  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr    <= 2'd0;
      r_len     <= 6'd0;
      r_wr_idx  <= 6'd0;
      r_rd_idx  <= 6'd0;
      r_parity  <= 8'd0;
      r_gap_cnt <= '0;
      r_done    <= 1'b0;
      r_req_err <= 1'b0;
    end else begin
      r_done    <= 1'b0;
      r_req_err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            if (w_req_ok) begin
              r_addr   <= dest_addr;
              r_len    <= pay_len;
              r_wr_idx <= 6'd0;
              r_parity <= 8'd0;
            end else begin
              r_req_err <= 1'b1;
            end
          end
        end
        S_COLLECT: begin
          if (pay_valid) begin
            r_parity <= r_parity ^ pay_data;
            if (!w_last_wr) r_wr_idx <= r_wr_idx + 6'd1;
          end
        end
        S_HEADER: begin
          if (!busy) begin
            r_parity <= r_parity ^ w_header;
            r_rd_idx <= 6'd0;
          end
        end
        S_PAYLOAD: begin
          if (!busy && !w_last_rd) r_rd_idx <= r_rd_idx + 6'd1;
        end
        S_PARITY: begin
          if (!busy) begin
            r_gap_cnt <= '0;
            if (GAP_CYCLES == 0) r_done <= 1'b1;
          end
        end
        S_GAP: begin
          if (w_gap_end) r_done <= 1'b1;
          else           r_gap_cnt <= r_gap_cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (r_state == S_COLLECT && pay_valid) r_buf[r_wr_idx] <= pay_data;
  end

  always_comb begin
    data_out  = 8'h00;
    pkt_valid = 1'b0;
    pay_ready = 1'b0;
    tx_ready  = 1'b0;
    case (r_state)
      S_IDLE:    tx_ready  = 1'b1;
      S_COLLECT: pay_ready = 1'b1;
      S_HEADER: begin
        data_out  = w_header;
        pkt_valid = 1'b1;
      end
      S_PAYLOAD: begin
        data_out  = r_buf[r_rd_idx];
        pkt_valid = 1'b1;
      end
      S_PARITY:  data_out  = r_parity;
      default: ;
    endcase
  end

  assign done    = r_done;
  assign req_err = r_req_err;

endmodule
`default_nettype wire

// File: tb/tb_router_pkt_src.sv
`default_nettype none
// tb_router_pkt_src : randomized packet traffic checked against an expected byte stream
module tb_router_pkt_src;

  localparam int MAX_LEN    = 63;
  localparam int GAP_CYCLES = 1;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [1:0] dest_addr;
  logic [5:0] pay_len;
  logic [7:0] pay_data;
  logic       pay_valid;
  logic       pay_ready;
  logic       busy;
  logic [7:0] data_out;
  logic       pkt_valid;
  logic       tx_ready;
  logic       done;
  logic       req_err;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] g_pay[$];
  logic [7:0] g_got[$];

  always #5 clk = ~clk;

  router_pkt_src #(.MAX_LEN(MAX_LEN), .GAP_CYCLES(GAP_CYCLES)) dut (
    .clk(clk), .rst(rst), .start(start), .dest_addr(dest_addr), .pay_len(pay_len),
    .pay_data(pay_data), .pay_valid(pay_valid), .pay_ready(pay_ready), .busy(busy),
    .data_out(data_out), .pkt_valid(pkt_valid), .tx_ready(tx_ready), .done(done),
    .req_err(req_err)
  );

  // vmode: 0 continuous, 1 every other cycle, 2 random
  // bmode: 0 never busy, 1 random, 2 stall header 4 cycles and parity 2 cycles
  task automatic run_packet(input string name, input logic [1:0] addr, input int len,
                            input int vmode, input int bmode, input bit check_lat,
                            input bit poke_start);
    logic [7:0] pay[$];
    logic [7:0] exp_q[$];
    logic [7:0] hdr, par, b, prev_d;
    int acc = 0, nv = 0, cyc = 0, done_cyc = -1, hdr_cyc = -1, par_cyc = -1;
    int hstall = 0, pstall = 0;
    bit in_pkt = 0, par_done = 0, poked = 0, off = 0;
    bit prev_off = 0, prev_busy = 0, prev_pv = 0;
    hdr = {6'(len), addr};
    par = hdr;
    exp_q.push_back(hdr);
    for (int i = 0; i < len; i++) begin
      b = (g_pay.size() > i) ? g_pay[i] : 8'($urandom);
      pay.push_back(b);
      exp_q.push_back(b);
      par ^= b;
    end
    exp_q.push_back(par);
    g_got.delete();
    prev_d = 8'h00;

    @(posedge clk); #1;
    n_checks++;
    if (tx_ready !== 1'b1) begin
      n_fail++; $display("FAIL %s tx_ready_before_start: got %b expected 1", name, tx_ready);
    end
    start = 1'b1; dest_addr = addr; pay_len = 6'(len); pay_valid = 1'b0; busy = 1'b0;

    while (cyc < 2000) begin
      @(posedge clk); #1;
      cyc++;
      start = 1'b0;
      if (acc < len) begin
        case (vmode)
          0:       pay_valid = 1'b1;
          1:       pay_valid = (cyc % 2 == 1);
          default: pay_valid = 1'($urandom_range(0, 1));
        endcase
      end else begin
        pay_valid = 1'b0;
      end
      pay_data = pay_valid ? pay[acc] : 8'($urandom);
      case (bmode)
        0: busy = 1'b0;
        1: busy = 1'($urandom_range(0, 1));
        default: begin
          busy = 1'b0;
          if (pkt_valid && g_got.size() == 0 && hstall < 4) begin busy = 1'b1; hstall++; end
          if (in_pkt && !pkt_valid && pstall < 2) begin busy = 1'b1; pstall++; end
        end
      endcase
      if (poke_start && !poked && pkt_valid && g_got.size() >= 2) begin
        start = 1'b1; dest_addr = 2'd0; pay_len = 6'd4; poked = 1'b1;
      end

      @(negedge clk);
      if (pay_ready && pay_valid) acc++;
      if (prev_off && prev_busy) begin
        n_checks++;
        if (data_out !== prev_d || pkt_valid !== prev_pv) begin
          n_fail++;
          $display("FAIL %s hold_under_busy: got %h/%b expected %h/%b", name, data_out, pkt_valid, prev_d, prev_pv);
        end
      end
      off = 1'b0;
      if (pkt_valid) begin
        in_pkt = 1'b1; off = 1'b1;
        if (hdr_cyc < 0) hdr_cyc = cyc;
        if (!busy) begin g_got.push_back(data_out); nv++; end
      end else if (in_pkt) begin
        off = 1'b1;
        if (par_cyc < 0) par_cyc = cyc;
        if (!busy) begin g_got.push_back(data_out); in_pkt = 1'b0; par_done = 1'b1; end
      end else if (par_done) begin
        n_checks++;
        if (data_out !== 8'h00 || pkt_valid !== 1'b0) begin
          n_fail++; $display("FAIL %s gap_idle: got %h/%b expected 00/0", name, data_out, pkt_valid);
        end
      end
      prev_off = off; prev_busy = busy; prev_d = data_out; prev_pv = pkt_valid;
      if (done) begin done_cyc = cyc; break; end
    end
    busy = 1'b0; pay_valid = 1'b0; start = 1'b0;

    n_checks++;
    if (done_cyc < 0) begin n_fail++; $display("FAIL %s done_timeout: got none expected pulse", name); end
    n_checks++;
    if (g_got.size() != len + 2) begin
      n_fail++; $display("FAIL %s transfer_count: got %0d expected %0d", name, g_got.size(), len + 2);
    end
    n_checks++;
    if (nv != len + 1) begin n_fail++; $display("FAIL %s valid_count: got %0d expected %0d", name, nv, len + 1); end
    for (int i = 0; i < exp_q.size() && i < g_got.size(); i++) begin
      n_checks++;
      if (g_got[i] !== exp_q[i]) begin
        n_fail++; $display("FAIL %s byte[%0d]: got %h expected %h", name, i, g_got[i], exp_q[i]);
      end
    end
    if (check_lat) begin
      n_checks++;
      if (hdr_cyc != len + 1 || par_cyc != 2 * len + 2 || done_cyc != 2 * len + 3 + GAP_CYCLES) begin
        n_fail++;
        $display("FAIL %s latency: got hdr %0d par %0d done %0d expected %0d %0d %0d", name,
                 hdr_cyc, par_cyc, done_cyc, len + 1, 2 * len + 2, 2 * len + 3 + GAP_CYCLES);
      end
    end
    @(posedge clk); #1;
    @(negedge clk);
    n_checks++;
    if (done !== 1'b0 || tx_ready !== 1'b1) begin
      n_fail++; $display("FAIL %s done_single_pulse: got done %b tx_ready %b expected 0 1", name, done, tx_ready);
    end
    if (poke_start) begin
      for (int i = 0; i < 4; i++) begin
        @(negedge clk);
        n_checks++;
        if (pay_ready !== 1'b0 || pkt_valid !== 1'b0 || tx_ready !== 1'b1) begin
          n_fail++; $display("FAIL %s second_packet: got pay_ready %b pkt_valid %b expected 0 0", name, pay_ready, pkt_valid);
        end
      end
    end
    g_pay.delete();
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; dest_addr = 2'd0; pay_len = 6'd0;
    pay_data = 8'h00; pay_valid = 1'b0; busy = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({data_out, pkt_valid, pay_ready, done, req_err, tx_ready} !== {8'h00, 5'b00001}) begin
      n_fail++;
      $display("FAIL reset_values: got d=%h v=%b pr=%b dn=%b re=%b tr=%b expected 00 0 0 0 0 1",
               data_out, pkt_valid, pay_ready, done, req_err, tx_ready);
    end
  endtask

  task automatic test_reset_mid;
    @(posedge clk); #1;
    start = 1'b1; dest_addr = 2'd0; pay_len = 6'd5; busy = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      @(posedge clk); #1;
      start = 1'b0; pay_valid = (i <= 5); pay_data = 8'(i * 7);
    end
    @(negedge clk);
    n_checks++;
    if (pkt_valid !== 1'b1) begin n_fail++; $display("FAIL reset_mid_in_payload: got %b expected 1", pkt_valid); end
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (pkt_valid !== 1'b0 || data_out !== 8'h00 || tx_ready !== 1'b1 || pay_ready !== 1'b0) begin
      n_fail++; $display("FAIL reset_mid_state: got v=%b d=%h tr=%b expected 0 00 1", pkt_valid, data_out, tx_ready);
    end
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      n_checks++;
      if (done !== 1'b0 || pkt_valid !== 1'b0) begin
        n_fail++; $display("FAIL reset_mid_quiet: got done %b pkt_valid %b expected 0 0", done, pkt_valid);
      end
    end
  endtask

  task automatic test_basic;
    g_pay = '{8'h11, 8'h22, 8'h33};
    run_packet("basic", 2'd1, 3, 0, 0, 1'b1, 1'b0);
    n_checks++;
    if (g_got != '{8'h0D, 8'h11, 8'h22, 8'h33, 8'h0D}) begin
      n_fail++; $display("FAIL basic_stream: got %p expected 0d 11 22 33 0d", g_got);
    end
  endtask

  task automatic test_busy_hold;
    g_pay = '{8'hA5};
    run_packet("busy_hold", 2'd2, 1, 0, 2, 1'b0, 1'b0);
    n_checks++;
    if (g_got != '{8'h06, 8'hA5, 8'hA3}) begin
      n_fail++; $display("FAIL busy_hold_stream: got %p expected 06 a5 a3", g_got);
    end
  endtask

  task automatic test_illegal;
    logic [1:0] a_tab [2] = '{2'd3, 2'd1};
    logic [5:0] l_tab [2] = '{6'd5, 6'd0};
    int pulses = 0;
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      start = 1'b1; dest_addr = a_tab[k]; pay_len = l_tab[k];
      @(posedge clk); #1 start = 1'b0;
      @(negedge clk);
      if (req_err) pulses++;
      n_checks++;
      if (req_err !== 1'b1 || tx_ready !== 1'b1 || pkt_valid !== 1'b0 || pay_ready !== 1'b0) begin
        n_fail++; $display("FAIL illegal_%0d: got re=%b tr=%b v=%b pr=%b expected 1 1 0 0", k, req_err, tx_ready, pkt_valid, pay_ready);
      end
      @(negedge clk);
      n_checks++;
      if (req_err !== 1'b0 || tx_ready !== 1'b1 || pkt_valid !== 1'b0) begin
        n_fail++; $display("FAIL illegal_%0d_after: got re=%b tr=%b v=%b expected 0 1 0", k, req_err, tx_ready, pkt_valid);
      end
    end
    n_checks++;
    if (pulses != 2) begin n_fail++; $display("FAIL illegal_pulses: got %0d expected 2", pulses); end
  endtask

  task automatic test_max_len;
    run_packet("max_len", 2'($urandom_range(0, 2)), MAX_LEN, 1, 1, 1'b0, 1'b0);
  endtask

  task automatic test_start_ignored;
    run_packet("start_ignored", 2'd1, 6, 0, 1, 1'b0, 1'b1);
  endtask

  task automatic test_random;
    for (int k = 0; k < 6; k++) begin
      run_packet($sformatf("random_%0d", k), 2'($urandom_range(0, 2)), $urandom_range(1, 20),
                 $urandom_range(0, 2), $urandom_range(0, 1), 1'b0, 1'b0);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_busy_hold();
    test_illegal();
    test_max_len();
    test_start_ignored();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/router_pkt_src.md
Name: router_pkt_src

Overview:
- Packet transmitter that drives the input port of the 1x3 router: source side of the pkt_valid/busy/data byte interface.
- Accepts a packet request (destination, payload length), collects payload bytes into an internal buffer, then emits header, payload and parity bytes.
- Honours router busy back-pressure. Used as the traffic generator ahead of the router in the top-level and in system benches.

Parameters:
MAX_LEN, 63, largest payload length accepted (1..63); sets buffer depth
GAP_CYCLES, 1, idle cycles (pkt_valid=0, no byte offered) after parity before done pulse / next packet

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous reset, active-high
start  input  1  packet request; sampled only in IDLE
dest_addr  input  2  destination port 0..2; 3 is illegal
pay_len  input  6  payload byte count; 0 is illegal
pay_data  input  8  payload byte from upstream
pay_valid  input  1  pay_data valid
pay_ready  output  1  block accepts pay_data this cycle
busy  input  1  router back-pressure; byte on data_out not consumed while high
data_out  output  8  byte to router
pkt_valid  output  1  high while header/payload on data_out; low during parity
tx_ready  output  1  high in IDLE only
done  output  1  one-cycle pulse after packet complete
req_err  output  1  one-cycle pulse: start rejected

Behaviour:
- Reset (synchronous, rst=1 at edge) from any state, including mid-packet: state=IDLE, all counters/parity cleared.
- Output reset values: data_out=0, pkt_valid=0, pay_ready=0, done=0, req_err=0, tx_ready=1.
- States: IDLE, COLLECT, HEADER, PAYLOAD, PARITY, GAP. All outputs registered or decoded from state only; none are combinational from busy or pay_valid.
- IDLE:
  - start=1 with dest_addr!=3, 1<=pay_len<=MAX_LEN: latch addr/len, clear write index and parity, go to COLLECT.
  - Illegal request: req_err pulses the next cycle; stay IDLE.
  - start outside IDLE is ignored.
- COLLECT:
  - pay_ready=1. Each edge with pay_valid=1 writes buffer[wr_idx] and parity ^= pay_data.
  - After byte len-1 is written, go to HEADER. No timeout.
- HEADER:
  - data_out={len[5:0],addr[1:0]}, pkt_valid=1.
  - Transfer occurs on an edge where busy=0; parity ^= header, rd_idx=0, go to PAYLOAD.
- PAYLOAD:
  - data_out=buffer[rd_idx], pkt_valid=1.
  - Each edge with busy=0 advances rd_idx. After byte len-1 transfers, go to PARITY.
  - While busy=1, data_out and pkt_valid hold unchanged.
- PARITY:
  - data_out=XOR of header and all payload bytes, pkt_valid=0.
  - On edge with busy=0, go to GAP.
- GAP: pkt_valid=0, data_out=0 for GAP_CYCLES cycles. done=1 in the cycle state returns to IDLE.
- Byte counts: one transfer = one edge with the byte presented and busy=0. A packet is exactly len+2 transfers; pkt_valid is high for exactly len+1 of them.
- Minimum latency, busy=0, pay_valid continuous:
  - start edge t.
  - Payload accepted at edges t+1..t+len.
  - Header on data_out cycle t+len+1.
  - Parity presented cycle t+2*len+2.
  - done in cycle t+2*len+3+GAP_CYCLES.
- Buffer indices are 6-bit. No wrap: index never exceeds len-1.

Test Plan:
- rst=1 for 2 cycles mid-PAYLOAD -> next cycle: IDLE, pkt_valid=0, data_out=0, tx_ready=1; no done pulse.
- addr=1, len=3, bytes 0x11,0x22,0x33, busy=0 -> data_out 0x0D,0x11,0x22,0x33 with pkt_valid=1, then 0x0D with pkt_valid=0; done after 1 gap cycle.
- addr=2, len=1, byte 0xA5; busy=1 for 4 cycles during HEADER and 2 cycles during PARITY -> header 0x06 and parity 0xA3 held stable throughout; exactly 3 transfers.
- start with dest_addr=3, then start with pay_len=0 -> req_err pulses twice, tx_ready stays 1, pkt_valid never rises.
- len=63, pay_valid toggling every other cycle, busy random -> 65 transfers, pkt_valid high for 64; parity equals XOR of header 0xFC|addr and all bytes.
- start pulsed during PAYLOAD -> ignored; the current packet completes intact and no second packet starts.
